// File: rtl/tx_mac.sv
// Gigabit Ethernet transmit MAC: wraps AXI-Stream frames with preamble/SFD,
// pads short frames to 60 bytes, appends CRC-32 FCS and enforces the inter-frame gap.
module tx_mac #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_tx_axis_tdata,
  input  logic                  s_tx_axis_tvalid,
  input  logic                  s_tx_axis_tlast,
  input  logic                  s_tx_axis_tuser,
  output logic                  s_tx_axis_trdy,
  output logic [DATA_WIDTH-1:0] rgmii_mac_tx_data,
  output logic                  rgmii_mac_tx_en,
  output logic                  rgmii_mac_tx_er
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, PAD, FCS, ERROR, IFG} state_t;

  state_t      state;
  logic [2:0]  pre_cnt;
  logic [10:0] byte_cnt;
  logic [31:0] crc;
  logic [1:0]  fcs_idx;
  logic [3:0]  ifg_cnt;
  logic        accept;
  logic [10:0] cnt_inc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign accept  = s_tx_axis_tvalid && s_tx_axis_trdy;
  assign cnt_inc = (byte_cnt == 11'd2047) ? byte_cnt : byte_cnt + 11'd1;

  // Every output is registered: each state loads what the line shows on the next cycle.
  // trdy rises while the SFD is on the line so the first byte follows the SFD gaplessly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      s_tx_axis_trdy    <= 1'b0;
      rgmii_mac_tx_data <= '0;
      rgmii_mac_tx_en   <= 1'b0;
      rgmii_mac_tx_er   <= 1'b0;
      pre_cnt           <= 3'd0;
      byte_cnt          <= 11'd0;
      crc               <= 32'hFFFFFFFF;
      fcs_idx           <= 2'd0;
      ifg_cnt           <= 4'd0;
    end else begin
      s_tx_axis_trdy    <= 1'b0;
      rgmii_mac_tx_data <= '0;
      rgmii_mac_tx_en   <= 1'b0;
      rgmii_mac_tx_er   <= 1'b0;
      case (state)
        IDLE: begin
          if (s_tx_axis_tvalid) begin
            rgmii_mac_tx_data <= 8'h55;
            rgmii_mac_tx_en   <= 1'b1;
            pre_cnt           <= 3'd1;
            state             <= PREAMBLE;
          end
        end
        PREAMBLE: begin
          rgmii_mac_tx_en <= 1'b1;
          pre_cnt         <= pre_cnt + 3'd1;
          if (pre_cnt == 3'd7) begin
            rgmii_mac_tx_data <= 8'hD5;
            s_tx_axis_trdy    <= 1'b1;
            crc               <= 32'hFFFFFFFF;
            byte_cnt          <= 11'd0;
            state             <= PAYLOAD;
          end else begin
            rgmii_mac_tx_data <= 8'h55;
          end
        end
        PAYLOAD: begin
          rgmii_mac_tx_en <= 1'b1;
          if (accept) begin
            rgmii_mac_tx_data <= s_tx_axis_tdata;
            byte_cnt          <= cnt_inc;
            crc               <= crc_byte(crc, s_tx_axis_tdata);
            if (s_tx_axis_tlast) begin
              if (s_tx_axis_tuser) begin
                rgmii_mac_tx_er <= 1'b1;
                ifg_cnt         <= 4'd0;
                state           <= IFG;
              end else if (byte_cnt < 11'd59) begin
                state <= PAD;
              end else begin
                fcs_idx <= 2'd0;
                state   <= FCS;
              end
            end else begin
              s_tx_axis_trdy <= 1'b1;
            end
          end else begin
            rgmii_mac_tx_er <= 1'b1;
            s_tx_axis_trdy  <= 1'b1;
            state           <= ERROR;
          end
        end
        PAD: begin
          rgmii_mac_tx_en <= 1'b1;
          byte_cnt        <= cnt_inc;
          crc             <= crc_byte(crc, 8'h00);
          if (byte_cnt == 11'd59) begin
            fcs_idx <= 2'd0;
            state   <= FCS;
          end
        end
        FCS: begin
          rgmii_mac_tx_en   <= 1'b1;
          rgmii_mac_tx_data <= ~crc[{fcs_idx, 3'b000} +: 8];
          fcs_idx           <= fcs_idx + 2'd1;
          if (fcs_idx == 2'd3) begin
            ifg_cnt <= 4'd0;
            state   <= IFG;
          end
        end
        ERROR: begin
          if (accept && s_tx_axis_tlast) begin
            ifg_cnt <= 4'd0;
            state   <= IFG;
          end else begin
            s_tx_axis_trdy <= 1'b1;
          end
        end
        IFG: begin
          ifg_cnt <= ifg_cnt + 4'd1;
          if (ifg_cnt == 4'd11) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_mac.sv
// Directed self-checking bench for tx_mac: captures the RGMII side every cycle and
// compares it against streams built from a bench-side CRC-32 model.
module tb_tx_mac;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s_tx_axis_tdata;
  logic       s_tx_axis_tvalid;
  logic       s_tx_axis_tlast;
  logic       s_tx_axis_tuser;
  logic       s_tx_axis_trdy;
  logic [7:0] rgmii_mac_tx_data;
  logic       rgmii_mac_tx_en;
  logic       rgmii_mac_tx_er;

  int vecCount  = 0;
  int missCount = 0;

  logic [7:0]  frm [0:255];
  logic [10:0] capQ[$];
  logic [10:0] expQ[$];
  bit          capOn = 1'b0;

  tx_mac #(.DATA_WIDTH(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .s_tx_axis_tdata   (s_tx_axis_tdata),
    .s_tx_axis_tvalid  (s_tx_axis_tvalid),
    .s_tx_axis_tlast   (s_tx_axis_tlast),
    .s_tx_axis_tuser   (s_tx_axis_tuser),
    .s_tx_axis_trdy    (s_tx_axis_trdy),
    .rgmii_mac_tx_data (rgmii_mac_tx_data),
    .rgmii_mac_tx_en   (rgmii_mac_tx_en),
    .rgmii_mac_tx_er   (rgmii_mac_tx_er)
  );

  always #5 clk = ~clk;

  // One capture entry per cycle: {trdy, en, er, data}
  always @(negedge clk) begin
    if (capOn)
      capQ.push_back({s_tx_axis_trdy, rgmii_mac_tx_en, rgmii_mac_tx_er, rgmii_mac_tx_data});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int countBit(input int b);
    int n = 0;
    foreach (capQ[i]) if (capQ[i][b]) n++;
    return n;
  endfunction

  task automatic expPush(input bit dc, input bit e, input bit r, input logic [7:0] d);
    expQ.push_back({dc, e, r, d});
  endtask

  // Expected line stream for a good frame: MSB-first CRC on bit-reflected input
  task automatic expFrame(input int base, input int n);
    logic [31:0] c;
    logic [31:0] f;
    logic [7:0]  b;
    logic        fb;
    int          total;
    repeat (7) expPush(0, 1, 0, 8'h55);
    expPush(0, 1, 0, 8'hD5);
    c = 32'hFFFFFFFF;
    total = (n < 60) ? 60 : n;
    for (int i = 0; i < total; i++) begin
      b = (i < n) ? frm[base + i] : 8'h00;
      expPush(0, 1, 0, b);
      for (int k = 0; k < 8; k++) begin
        fb = b[k] ^ c[31];
        c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
      end
    end
    for (int k = 0; k < 32; k++) f[k] = ~c[31 - k];
    for (int k = 0; k < 4; k++) expPush(0, 1, 0, f[8*k +: 8]);
    repeat (12) expPush(0, 0, 0, 8'h00);
  endtask

  task automatic compareStream(input string tag);
    int first = -1;
    logic [31:0] o;
    logic [31:0] e;
    for (int i = 0; i < capQ.size(); i++)
      if (first < 0 && capQ[i][9]) first = i;
    checkOutput($sformatf("%s frame start seen", tag), (first >= 0), 1);
    if (first >= 0) begin
      for (int j = 0; j < expQ.size(); j++) begin
        o = (first + j < capQ.size()) ? {22'h0, capQ[first + j][9:0]} : 32'hFFFFFFFF;
        e = {22'h0, expQ[j][9:0]};
        if (expQ[j][10]) begin
          o = o & 32'h300;
          e = e & 32'h300;
        end
        checkOutput($sformatf("%s cycle %0d {en,er,data}", tag, j), o, e);
      end
    end
  endtask

  // Drives one frame from frm[base..]; optionally withholds tvalid for 3 ready cycles at byte dropAt
  task automatic applyStimulus(input int base, input int len, input int dropAt, input bit errLast);
    int idx = 0;
    int drops = 0;
    int guard = 0;
    bit hs;
    while (idx < len) begin
      if (idx == dropAt && drops < 3 && s_tx_axis_trdy) begin
        s_tx_axis_tvalid = 1'b0;
        drops++;
      end else begin
        s_tx_axis_tvalid = 1'b1;
        s_tx_axis_tdata  = frm[base + idx];
        s_tx_axis_tlast  = (idx == len - 1);
        s_tx_axis_tuser  = errLast && (idx == len - 1);
      end
      hs = s_tx_axis_tvalid && s_tx_axis_trdy;
      @(negedge clk);
      if (hs) idx++;
      guard++;
      if (guard > 3000) begin
        checkOutput("stimulus handshake budget", idx, len);
        break;
      end
    end
  endtask

  task automatic idleInputs();
    s_tx_axis_tvalid = 1'b0;
    s_tx_axis_tlast  = 1'b0;
    s_tx_axis_tuser  = 1'b0;
    s_tx_axis_tdata  = 8'h00;
  endtask

  initial begin
    int k6;
    reset = 1'b1;
    idleInputs();
    repeat (3) @(negedge clk);
    checkOutput("reset trdy", s_tx_axis_trdy, 0);
    checkOutput("reset tx_en", rgmii_mac_tx_en, 0);
    checkOutput("reset tx_er", rgmii_mac_tx_er, 0);
    checkOutput("reset tx_data", rgmii_mac_tx_data, 0);
    reset = 1'b0;

    // 60-byte frame, no padding needed
    for (int i = 0; i < 60; i++) frm[i] = 8'(i);
    capQ.delete(); capOn = 1'b1;
    applyStimulus(0, 60, -1, 1'b0);
    idleInputs();
    repeat (60) @(negedge clk);
    capOn = 1'b0;
    expQ.delete(); expFrame(0, 60);
    compareStream("t1");
    checkOutput("t1 tx_en cycles", countBit(9), 72);
    checkOutput("t1 trdy cycles", countBit(10), 60);
    checkOutput("t1 tx_er cycles", countBit(8), 0);

    // single byte, padded to 60
    @(negedge clk);
    frm[0] = 8'hAB;
    capQ.delete(); capOn = 1'b1;
    applyStimulus(0, 1, -1, 1'b0);
    idleInputs();
    repeat (100) @(negedge clk);
    capOn = 1'b0;
    expQ.delete(); expFrame(0, 1);
    compareStream("t2");
    checkOutput("t2 tx_en cycles", countBit(9), 72);
    checkOutput("t2 trdy cycles", countBit(10), 1);

    // two 64-byte frames back to back, tvalid never drops
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      frm[i]      = 8'(i * 3 + 1);
      frm[64 + i] = 8'(255 - i);
    end
    capQ.delete(); capOn = 1'b1;
    applyStimulus(0, 64, -1, 1'b0);
    applyStimulus(64, 64, -1, 1'b0);
    idleInputs();
    repeat (100) @(negedge clk);
    capOn = 1'b0;
    expQ.delete(); expFrame(0, 64); expFrame(64, 64);
    compareStream("t3");
    checkOutput("t3 tx_en cycles", countBit(9), 152);
    checkOutput("t3 trdy cycles", countBit(10), 128);

    // underrun at byte 20 of 100
    @(negedge clk);
    for (int i = 0; i < 100; i++) frm[i] = 8'(i + 16);
    capQ.delete(); capOn = 1'b1;
    applyStimulus(0, 100, 20, 1'b0);
    idleInputs();
    repeat (100) @(negedge clk);
    capOn = 1'b0;
    expQ.delete();
    repeat (7) expPush(0, 1, 0, 8'h55);
    expPush(0, 1, 0, 8'hD5);
    for (int i = 0; i < 20; i++) expPush(0, 1, 0, frm[i]);
    expPush(1, 1, 1, 8'h00);
    repeat (150) expPush(1, 0, 0, 8'h00);
    compareStream("t4");
    checkOutput("t4 tx_en cycles", countBit(9), 29);
    checkOutput("t4 tx_er cycles", countBit(8), 1);
    checkOutput("t4 trdy cycles", countBit(10), 103);

    // errored frame: tuser on the 70th (last) byte
    @(negedge clk);
    for (int i = 0; i < 70; i++) frm[i] = 8'(200 - i);
    capQ.delete(); capOn = 1'b1;
    applyStimulus(0, 70, -1, 1'b1);
    idleInputs();
    repeat (60) @(negedge clk);
    capOn = 1'b0;
    expQ.delete();
    repeat (7) expPush(0, 1, 0, 8'h55);
    expPush(0, 1, 0, 8'hD5);
    for (int i = 0; i < 69; i++) expPush(0, 1, 0, frm[i]);
    expPush(0, 1, 1, frm[69]);
    repeat (12) expPush(0, 0, 0, 8'h00);
    compareStream("t5");
    checkOutput("t5 tx_en cycles", countBit(9), 78);
    checkOutput("t5 tx_er cycles", countBit(8), 1);

    // reset while the second FCS byte is on the line
    @(negedge clk);
    for (int i = 0; i < 60; i++) frm[128 + i] = 8'(i * 7 + 5);
    capQ.delete(); capOn = 1'b1;
    applyStimulus(128, 60, -1, 1'b0);
    idleInputs();
    k6 = 0;
    while (k6 < 200 && countBit(9) < 70) begin
      @(negedge clk); #1;
      k6++;
    end
    checkOutput("t6 reached FCS byte 2", countBit(9), 70);
    expQ.delete(); expFrame(128, 60);
    checkOutput("t6 FCS byte 2 value", rgmii_mac_tx_data, expQ[69][7:0]);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t6 tx_en after reset", rgmii_mac_tx_en, 0);
    checkOutput("t6 trdy after reset", s_tx_axis_trdy, 0);
    checkOutput("t6 tx_er after reset", rgmii_mac_tx_er, 0);
    checkOutput("t6 tx_data after reset", rgmii_mac_tx_data, 0);
    @(negedge clk);
    reset = 1'b0;
    capQ.delete();
    frm[200] = 8'h5A;
    applyStimulus(200, 1, -1, 1'b0);
    idleInputs();
    repeat (100) @(negedge clk);
    capOn = 1'b0;
    expQ.delete(); expFrame(200, 1);
    compareStream("t6");
    checkOutput("t6 tx_en cycles after reset", countBit(9), 72);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
